// File: rtl/ws2811_pixel_shifter.sv
// ws2811_pixel_shifter
// Serializes 24-bit pixel words MSB-first onto a WS2811 data line, using the
// slot strobes from ws2811_clk. A one-entry holding buffer decouples the
// upstream handshake from the bit-slot timing. Every frame of NUM_PIXELS
// pixels (or a frame cut short by an empty buffer) is followed by a
// forced-low latch interval of RESET_SLOTS slots.
module ws2811_pixel_shifter #(
    parameter int NUM_PIXELS  = 8,
    parameter int RESET_SLOTS = 24,
    parameter int PIX_W       = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_lo,
    input  logic             clk_hi,
    input  logic             clk_bit,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             dout,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int IDX_W  = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
    localparam int SLOT_W = (RESET_SLOTS > 1) ? $clog2(RESET_SLOTS) : 1;

    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(PIX_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_PIXELS);
    localparam logic [SLOT_W-1:0] SLOT_TOP = SLOT_W'(RESET_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t             state;
    logic               buf_full;
    logic [PIX_W-1:0]   buf_data;
    logic [PIX_W-1:0]   shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic [CNT_W-1:0]   pix_cnt;
    logic [SLOT_W-1:0]  slot_cnt;

    logic               last_bit;
    logic               more_pix;
    logic               load_now;
    logic               drive_p0;
    logic               bit_p0;

    assign last_bit  = (bit_idx == '0);
    assign more_pix  = (pix_cnt < CNT_FULL);
    assign pix_ready = ~buf_full;
    assign busy      = (state != IDLE);

    // Decide whether this slot boundary moves the buffered pixel into the shifter
    always_comb begin
        load_now = 1'b0;
        if (clk_bit && buf_full) begin
            if (state == IDLE) begin
                load_now = 1'b1;
            end else if (state == SHIFT && last_bit && more_pix) begin
                load_now = 1'b1;
            end
        end
    end

    // Stage p0: drive enable and bit value that take effect this cycle
    // (on a slot boundary these are the post-transition values, so the
    // new bit is visible on the very first cycle of its slot)
    always_comb begin
        drive_p0 = (state == SHIFT);
        bit_p0   = shreg[PIX_W-1];
        if (clk_bit) begin
            if (load_now) begin
                drive_p0 = 1'b1;
                bit_p0   = buf_data[PIX_W-1];
            end else if (state == SHIFT && !last_bit) begin
                drive_p0 = 1'b1;
                bit_p0   = shreg[PIX_W-2];
            end else begin
                drive_p0 = 1'b0;
            end
        end
    end

    // Buffer, shifter, frame FSM and registered line/pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            pix_cnt    <= '0;
            slot_cnt   <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            // Stage p0 -> line: dout lags the strobes by one cycle
            dout <= drive_p0 & (bit_p0 ? clk_hi : clk_lo);

            // Fill and drain never coincide: filling needs the buffer empty,
            // draining needs it full
            if (pix_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= pix_data;
            end
            if (load_now) begin
                buf_full <= 1'b0;
                shreg    <= buf_data;
                bit_idx  <= IDX_TOP;
            end

            if (clk_bit) begin
                case (state)
                    IDLE: begin
                        if (load_now) begin
                            pix_cnt <= CNT_W'(1);
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (!last_bit) begin
                            shreg   <= shreg << 1;
                            bit_idx <= bit_idx - 1'b1;
                        end else if (load_now) begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end else begin
                            // Either the frame is complete, or the buffer ran
                            // dry mid-frame and the partial frame is latched
                            state    <= LATCH;
                            slot_cnt <= SLOT_TOP;
                            if (more_pix) begin
                                underrun <= 1'b1;
                            end
                        end
                    end
                    LATCH: begin
                        if (slot_cnt == '0) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            slot_cnt <= slot_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
